// File: rtl/wb_dma_master_if.sv
// Wishbone master-port bundle for the DMA engine.
// Classic single-cycle strobe/ack handshake, 32-bit data.
interface wb_dma_master_if;
   logic [31:0] m_adr_o;
   logic [31:0] m_dat_o;
   logic [31:0] m_dat_i;
   logic [3:0]  m_sel_o;
   logic        m_we_o;
   logic        m_stb_o;
   logic        m_ack_i;

   modport master (
      output m_adr_o, m_dat_o, m_sel_o,
      output m_we_o, m_stb_o,
      input  m_dat_i, m_ack_i
   );

   modport slave (
      input  m_adr_o, m_dat_o, m_sel_o,
      input  m_we_o, m_stb_o,
      output m_dat_i, m_ack_i
   );
endinterface

// File: rtl/wb_dma_master.sv
// Wishbone DMA master: word-by-word read/write copy engine
// with bus timeout, abort and a level completion interrupt.
module wb_dma_master #(
   parameter int LEN_W   = 12,
   parameter int TIMEOUT = 255
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [31:0]      src_i,
   input  logic [31:0]      dst_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic             irq_ack_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic             irq_o,
   output logic [LEN_W-1:0] remain_o,
   wb_dma_master_if.master  m
);

   typedef enum logic [2:0] {
      IDLE, RD, RGAP, WR, WGAP, FIN, ERR
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic [31:0] cur_src;
   logic [31:0] cur_dst;
   logic [7:0]  tmo;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         cur_src   <= '0;
         cur_dst   <= '0;
         tmo       <= '0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         err_o     <= 1'b0;
         irq_o     <= 1'b0;
         remain_o  <= '0;
         m.m_adr_o <= '0;
         m.m_dat_o <= '0;
         m.m_sel_o <= '0;
         m.m_we_o  <= 1'b0;
         m.m_stb_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         // later set of irq_o in this block overrides the ack clear
         if (irq_ack_i)
            irq_o <= 1'b0;
         if (state != IDLE && abort_i) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            m.m_stb_o <= 1'b0;
            m.m_sel_o <= '0;
            m.m_we_o  <= 1'b0;
            if (state == WR && m.m_ack_i)
               remain_o <= remain_o - LEN_W'(1);
         end else begin
            unique case (state)
               IDLE: begin
                  if (start_i) begin
                     cur_src  <= {src_i[31:2], 2'b00};
                     cur_dst  <= {dst_i[31:2], 2'b00};
                     remain_o <= len_i;
                     err_o    <= 1'b0;
                     busy_o   <= 1'b1;
                     if (len_i == '0) begin
                        state <= FIN;
                     end else begin
                        state     <= RD;
                        tmo       <= '0;
                        m.m_adr_o <= {src_i[31:2], 2'b00};
                        m.m_stb_o <= 1'b1;
                        m.m_sel_o <= 4'hF;
                        m.m_we_o  <= 1'b0;
                     end
                  end
               end
               RD, WR: begin
                  if (m.m_ack_i) begin
                     m.m_stb_o <= 1'b0;
                     m.m_sel_o <= '0;
                     m.m_we_o  <= 1'b0;
                     if (state == RD) begin
                        m.m_dat_o <= m.m_dat_i;
                        cur_src   <= cur_src + 32'd4;
                        state     <= RGAP;
                     end else begin
                        cur_dst  <= cur_dst + 32'd4;
                        remain_o <= remain_o - LEN_W'(1);
                        state    <= WGAP;
                     end
                  end else if (tmo == TMO_LAST) begin
                     m.m_stb_o <= 1'b0;
                     m.m_sel_o <= '0;
                     m.m_we_o  <= 1'b0;
                     err_o     <= 1'b1;
                     irq_o     <= 1'b1;
                     state     <= ERR;
                  end else begin
                     tmo <= tmo + 8'd1;
                  end
               end
               RGAP: begin
                  state     <= WR;
                  tmo       <= '0;
                  m.m_adr_o <= cur_dst;
                  m.m_stb_o <= 1'b1;
                  m.m_sel_o <= 4'hF;
                  m.m_we_o  <= 1'b1;
               end
               WGAP: begin
                  if (remain_o == '0) begin
                     state <= FIN;
                  end else begin
                     state     <= RD;
                     tmo       <= '0;
                     m.m_adr_o <= cur_src;
                     m.m_stb_o <= 1'b1;
                     m.m_sel_o <= 4'hF;
                     m.m_we_o  <= 1'b0;
                  end
               end
               FIN: begin
                  done_o <= 1'b1;
                  irq_o  <= 1'b1;
                  busy_o <= 1'b0;
                  state  <= IDLE;
               end
               ERR: begin
                  busy_o <= 1'b0;
                  state  <= IDLE;
               end
               default: begin
                  busy_o <= 1'b0;
                  state  <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wb_dma_master.sv
// Directed bench for wb_dma_master: copy, empty copy, timeout,
// abort, address wrap with coincident irq ack, async reset.
module tb_wb_dma_master;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic        abort_i = 1'b0;
   logic [31:0] src_i = '0;
   logic [31:0] dst_i = '0;
   logic [11:0] len_i = '0;
   logic        irq_ack_i = 1'b0;
   logic        busy_o, done_o, err_o, irq_o;
   logic [11:0] remain_o;
   logic        ack_rd = 1'b1;
   logic        ack_wr = 1'b1;

   int checks = 0;
   int errors = 0;

   int rn = 0;
   int wn = 0;
   int done_cnt = 0;
   int stb_cnt = 0;
   logic [31:0] rd_adr [0:15];
   logic [31:0] wr_adr [0:15];
   logic [31:0] wr_dat [0:15];

   wb_dma_master_if bus ();

   wb_dma_master dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .start_i   (start_i),
      .abort_i   (abort_i),
      .src_i     (src_i),
      .dst_i     (dst_i),
      .len_i     (len_i),
      .irq_ack_i (irq_ack_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .err_o     (err_o),
      .irq_o     (irq_o),
      .remain_o  (remain_o),
      .m         (bus.master)
   );

   always #5 clk = ~clk;

   // zero-wait slave: read data is a fixed pattern of the address
   assign bus.m_dat_i = bus.m_adr_o ^ 32'hA5A5_0000;
   assign bus.m_ack_i = bus.m_stb_o &
                        (bus.m_we_o ? ack_wr : ack_rd);

   always @(posedge clk) begin
      if (bus.m_stb_o) stb_cnt <= stb_cnt + 1;
      if (done_o) done_cnt <= done_cnt + 1;
      if (bus.m_stb_o && bus.m_ack_i) begin
         if (bus.m_we_o) begin
            wr_adr[wn % 16] <= bus.m_adr_o;
            wr_dat[wn % 16] <= bus.m_dat_o;
            wn <= wn + 1;
         end else begin
            rd_adr[rn % 16] <= bus.m_adr_o;
            rn <= rn + 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_xfer(input logic [31:0] s,
                             input logic [31:0] d,
                             input logic [11:0] l);
      src_i = s;
      dst_i = d;
      len_i = l;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic clear_irq();
      irq_ack_i = 1'b1;
      tick();
      irq_ack_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      tick();
      checks++;
      if ({busy_o, done_o, err_o, irq_o} !== 4'b0 ||
          remain_o !== 12'd0 || bus.m_stb_o !== 1'b0 ||
          bus.m_we_o !== 1'b0 || bus.m_sel_o !== 4'h0 ||
          bus.m_adr_o !== 32'd0) begin
         errors++;
         $display("FAIL reset: busy=%b done=%b err=%b irq=%b rem=%0d stb=%b adr=%h, required all zero",
                  busy_o, done_o, err_o, irq_o, remain_o,
                  bus.m_stb_o, bus.m_adr_o);
      end
      rst_i = 1'b0;
      tick();
   endtask

   task automatic test_copy();
      int n, r0, w0, d0;
      logic [31:0] ea;
      r0 = rn; w0 = wn; d0 = done_cnt;
      start_xfer(32'h100, 32'h2000, 12'd3);
      n = 1;
      while (!done_o && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (n !== 14) begin
         errors++;
         $display("FAIL copy_latency: done after %0d cycles, required 14", n);
      end
      tick();
      tick();
      checks++;
      if (done_cnt - d0 !== 1 || irq_o !== 1'b1 ||
          busy_o !== 1'b0 || remain_o !== 12'd0) begin
         errors++;
         $display("FAIL copy_status: dones=%0d irq=%b busy=%b rem=%0d, required 1 1 0 0",
                  done_cnt - d0, irq_o, busy_o, remain_o);
      end
      checks++;
      if (rn - r0 !== 3 || wn - w0 !== 3) begin
         errors++;
         $display("FAIL copy_count: reads=%0d writes=%0d, required 3 3",
                  rn - r0, wn - w0);
      end
      for (int k = 0; k < 3; k++) begin
         ea = 32'h100 + 32'(4 * k);
         checks++;
         if (rd_adr[(r0 + k) % 16] !== ea ||
             wr_adr[(w0 + k) % 16] !== 32'h2000 + 32'(4 * k) ||
             wr_dat[(w0 + k) % 16] !== (ea ^ 32'hA5A5_0000)) begin
            errors++;
            $display("FAIL copy_word%0d: rd=%h wr=%h dat=%h, required %h %h %h",
                     k, rd_adr[(r0 + k) % 16], wr_adr[(w0 + k) % 16],
                     wr_dat[(w0 + k) % 16], ea,
                     32'h2000 + 32'(4 * k), ea ^ 32'hA5A5_0000);
         end
      end
      clear_irq();
   endtask

   task automatic test_len_zero();
      int n, s0;
      s0 = stb_cnt;
      start_xfer(32'h100, 32'h2000, 12'd0);
      n = 1;
      while (!done_o && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (n !== 2 || irq_o !== 1'b1 || remain_o !== 12'd0) begin
         errors++;
         $display("FAIL len_zero: done after %0d irq=%b rem=%0d, required 2 1 0",
                  n, irq_o, remain_o);
      end
      tick();
      checks++;
      if (stb_cnt !== s0) begin
         errors++;
         $display("FAIL len_zero_stb: stb cycles=%0d, required 0", stb_cnt - s0);
      end
      clear_irq();
   endtask

   task automatic test_timeout();
      int n, cnt, r0, d0;
      r0 = rn; d0 = done_cnt;
      start_xfer(32'h100, 32'h2000, 12'd3);
      n = 0;
      while (rn == r0 && n < 50) begin
         tick();
         n++;
      end
      ack_rd = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!(bus.m_stb_o && !bus.m_we_o) && n < 50);
      cnt = 0;
      while (bus.m_stb_o && cnt < 400) begin
         cnt++;
         tick();
      end
      checks++;
      if (cnt !== 255) begin
         errors++;
         $display("FAIL timeout_len: stb held %0d cycles, required 255", cnt);
      end
      checks++;
      if (err_o !== 1'b1 || irq_o !== 1'b1 || remain_o !== 12'd2) begin
         errors++;
         $display("FAIL timeout_flags: err=%b irq=%b rem=%0d, required 1 1 2",
                  err_o, irq_o, remain_o);
      end
      tick();
      checks++;
      if (busy_o !== 1'b0 || done_cnt !== d0 || err_o !== 1'b1) begin
         errors++;
         $display("FAIL timeout_end: busy=%b dones=%0d err=%b, required 0 0 1",
                  busy_o, done_cnt - d0, err_o);
      end
      ack_rd = 1'b1;
      clear_irq();
   endtask

   task automatic abort_run(input logic with_ack,
                            input logic [11:0] exp_rem);
      int n, w0, d0;
      w0 = wn; d0 = done_cnt;
      start_xfer(32'h100, 32'h2000, 12'd5);
      n = 0;
      while (wn == w0 && n < 50) begin
         tick();
         n++;
      end
      ack_wr = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!(bus.m_stb_o && bus.m_we_o) && n < 50);
      tick();
      ack_wr = with_ack;
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      ack_wr = 1'b1;
      checks++;
      if (busy_o !== 1'b0 || bus.m_stb_o !== 1'b0 ||
          remain_o !== exp_rem || irq_o !== 1'b0 ||
          err_o !== 1'b0) begin
         errors++;
         $display("FAIL abort_ack%0b: busy=%b stb=%b rem=%0d irq=%b err=%b, required 0 0 %0d 0 0",
                  with_ack, busy_o, bus.m_stb_o, remain_o, irq_o,
                  err_o, exp_rem);
      end
      tick();
      tick();
      checks++;
      if (done_cnt !== d0 || irq_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL abort_quiet%0b: dones=%0d irq=%b busy=%b, required 0 0 0",
                  with_ack, done_cnt - d0, irq_o, busy_o);
      end
   endtask

   task automatic test_abort();
      abort_run(1'b0, 12'd4);
      abort_run(1'b1, 12'd3);
   endtask

   task automatic test_wrap_irq_race();
      int n, r0, w0;
      r0 = rn; w0 = wn;
      start_xfer(32'hFFFF_FFFC, 32'h300, 12'd2);
      n = 0;
      while (wn < w0 + 2 && n < 50) begin
         tick();
         n++;
      end
      tick();
      irq_ack_i = 1'b1;
      tick();
      irq_ack_i = 1'b0;
      checks++;
      if (irq_o !== 1'b1 || done_o !== 1'b1) begin
         errors++;
         $display("FAIL irq_race: irq=%b done=%b, required 1 1", irq_o, done_o);
      end
      checks++;
      if (rd_adr[r0 % 16] !== 32'hFFFF_FFFC ||
          rd_adr[(r0 + 1) % 16] !== 32'h0 ||
          wr_adr[(w0 + 1) % 16] !== 32'h304) begin
         errors++;
         $display("FAIL wrap: rd0=%h rd1=%h wr1=%h, required fffffffc 00000000 00000304",
                  rd_adr[r0 % 16], rd_adr[(r0 + 1) % 16],
                  wr_adr[(w0 + 1) % 16]);
      end
      clear_irq();
      checks++;
      if (irq_o !== 1'b0) begin
         errors++;
         $display("FAIL irq_clear: irq=%b, required 0", irq_o);
      end
   endtask

   task automatic test_async_reset();
      int n, w0;
      start_xfer(32'h100, 32'h2000, 12'd3);
      #3;
      rst_i = 1'b1;
      #1;
      checks++;
      if (bus.m_stb_o !== 1'b0 || busy_o !== 1'b0 ||
          remain_o !== 12'd0) begin
         errors++;
         $display("FAIL async_reset: stb=%b busy=%b rem=%0d, required 0 0 0",
                  bus.m_stb_o, busy_o, remain_o);
      end
      tick();
      rst_i = 1'b0;
      tick();
      w0 = wn;
      start_xfer(32'h200, 32'h2100, 12'd2);
      n = 1;
      while (!done_o && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (n !== 10 || wn - w0 !== 2 ||
          wr_dat[(w0 + 1) % 16] !== (32'h204 ^ 32'hA5A5_0000)) begin
         errors++;
         $display("FAIL after_reset: done after %0d writes=%0d dat=%h, required 10 2 %h",
                  n, wn - w0, wr_dat[(w0 + 1) % 16],
                  32'h204 ^ 32'hA5A5_0000);
      end
   endtask

   initial begin
      test_reset();
      test_copy();
      test_len_zero();
      test_timeout();
      test_abort();
      test_wrap_irq_race();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
